prbs16_checker: RTL and testbench
=================================

Name: prbs16_checker

Overview:
- Receive-side partner of the 16-bit PRBS generator. Consumes the serial bit stream, self-synchronises a shadow LFSR to it, declares lock, then counts bit errors against the predicted sequence.
- Used for link/self-test of any path carrying PRBS data, e.g. a loop-back of the generator output.
- Polynomial matches the generator: next bit = r[15]^r[12]^r[11]^r[10], shifted into r[0], r shifts toward MSB.

Parameters:
- LOCK_COUNT, 32, consecutive correct predictions in VERIFY required to assert locked (1..255)
- LOSS_COUNT, 8, consecutive mismatches in LOCKED that drop lock (1..255)
- ERR_W, 16, width of errCount

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- bitEn  in  1  qualifies bitIn; one received bit per cycle with bitEn=1
- bitIn  in  1  received PRBS bit, i.e. the generator feedback bit of that shift
- clrCount  in  1  synchronous clear of errCount
- locked  out  1  registered; 1 while in LOCKED
- errPulse  out  1  registered; one-cycle pulse per counted error
- errCount  out  ERR_W  saturating count of errors seen while LOCKED
- state  out  2  current FSM state (debug): 0 SEED, 1 VERIFY, 2 LOCKED

Behaviour:
- Reset is synchronous, active-high. On rst: shadow=16'h0000, seedCnt=0, matchCnt=0, missCnt=0, state=SEED, locked=0, errPulse=0, errCount=0. rst overrides all other inputs.
- Nothing advances when bitEn=0. errPulse returns to 0 that cycle.
- pred = shadow[15]^shadow[12]^shadow[11]^shadow[10], computed combinationally from the current shadow.
- SEED:
  - on bitEn, shadow <= {shadow[14:0], bitIn}, seedCnt++.
  - When the 16th bit is absorbed, go to VERIFY with matchCnt=0.
- VERIFY:
  - on bitEn, shadow shifts in bitIn (received bit, not pred).
  - bitIn==pred: matchCnt++. Reaching LOCK_COUNT moves to LOCKED, with locked=1 from the next cycle.
  - Mismatch: matchCnt=0, stay in VERIFY.
  - If the shadow after the shift is 16'h0000: go to SEED with seedCnt=0. The all-zero state is illegal.
- LOCKED:
  - on bitEn, shadow shifts in pred (flywheel), so a single bit error does not corrupt the shadow.
  - Mismatch: errPulse=1 next cycle, errCount++ (saturates at all-ones), missCnt++.
  - Match: missCnt=0.
  - missCnt reaching LOSS_COUNT: go to SEED, locked=0 next cycle, seedCnt=0. The error that caused the loss is still counted.
- Latency: locked, errPulse and errCount update on the clock edge that samples the qualifying bitEn. They are visible the following cycle.
- clrCount alone sets errCount=0. clrCount together with a counted error sets errCount=1. clrCount does not affect lock state.
- errCount holds its value across lock loss. It is cleared only by rst or clrCount.
- Errors are never counted in SEED or VERIFY.
- Generator bypass: if the generator restarts from 16'hFFFF mid-stream, the checker sees a burst of mismatches. It either re-locks via LOSS_COUNT → SEED, or continues if the burst is shorter than LOSS_COUNT.

Decomposition:
- Shared package holds:
  - PRBS16 tap constants (15, 12, 11, 10)
  - state encoding constants (SEED=2'd0, VERIFY=2'd1, LOCKED=2'd2)
  - PRBS16 seed constant 16'hFFFF, shared with the generator.
- One natural sub-module, prbs16_predict: combinational next-bit from a 16-bit state. Reused by the generator and the checker so the polynomials cannot diverge.

Test Plan:
- Clean lock:
  - Stimulus: feed the generator stream from seed 16'hFFFF (first 11 bits are 0, 12th is 1), bitEn=1 every cycle.
  - Required: state=VERIFY after bit 16, locked=1 the cycle after bit 48, errCount=0 for the following 1000 bits.
- Single error:
  - Stimulus: locked, invert one bit.
  - Required: exactly one errPulse, errCount=1, locked stays 1, no further errors (flywheel).
- Loss of lock:
  - Stimulus: locked, force 8 consecutive inverted bits.
  - Required: errCount=8, locked=0 the cycle after the 8th bit, state=SEED; re-lock after a further 48 clean bits.
- Zero rejection:
  - Stimulus: 16 zero bits, then a constant 0 stream.
  - Required: cycles SEED→VERIFY→SEED, locked never asserts, errCount=0.
- bitEn gaps and clear:
  - Stimulus: bitEn toggled 1/0 during lock, then clrCount asserted in the same cycle as a counted error.
  - Required: lock time measured in bitEn cycles is unchanged (48 bits), and errCount=1 after the clear-with-error cycle.
- Reset mid-operation:
  - Stimulus: rst asserted while LOCKED with errCount=5.
  - Required: next cycle locked=0, errCount=0, state=SEED, errPulse=0.

Source files
------------

// File: rtl/prbs16_checker_pkg.sv
// Shared PRBS16 definitions: polynomial taps, seed value and checker state encoding.
package prbs16_checker_pkg;

  localparam int unsigned PRBS16_TAP_A = 15;
  localparam int unsigned PRBS16_TAP_B = 12;
  localparam int unsigned PRBS16_TAP_C = 11;
  localparam int unsigned PRBS16_TAP_D = 10;

  localparam logic [15:0] PRBS16_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chkState_t;

endpackage

// File: rtl/prbs16_predict.sv
// Combinational PRBS16 next-bit; shared by generator and checker so the polynomials stay identical.
module prbs16_predict
  import prbs16_checker_pkg::*;
(
  input  logic [15:0] lfsr,
  output logic        nextBit
);

  always_comb begin
    nextBit = lfsr[PRBS16_TAP_A] ^ lfsr[PRBS16_TAP_B] ^ lfsr[PRBS16_TAP_C] ^ lfsr[PRBS16_TAP_D];
  end

endmodule

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: seeds a shadow LFSR from the stream, verifies, locks, then counts bit errors.
module prbs16_checker
  import prbs16_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned LOSS_COUNT = 8,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bitEn,
  input  logic             bitIn,
  input  logic             clrCount,
  output logic             locked,
  output logic             errPulse,
  output logic [ERR_W-1:0] errCount,
  output logic [1:0]       state
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

  chkState_t   curState, nxtState;
  logic [15:0] shadow, shadowNxt;
  logic [4:0]  seedCnt;
  logic [7:0]  matchCnt, missCnt;
  logic        pred, bitOk, countErr;

  prbs16_predict uPredict (
    .lfsr    (shadow),
    .nextBit (pred)
  );

  // Once locked the shadow flywheels on its own prediction so line errors cannot corrupt it.
  always_comb begin
    bitOk     = (bitIn == pred);
    shadowNxt = (curState == LOCKED) ? {shadow[14:0], pred} : {shadow[14:0], bitIn};
  end

  always_ff @(posedge clk) begin
    if (rst) curState <= SEED;
    else     curState <= nxtState;
  end

  always_comb begin
    nxtState = curState;
    if (bitEn) begin
      case (curState)
        SEED:    if (seedCnt == 5'd15) nxtState = VERIFY;
        VERIFY: begin
          if (shadowNxt == '0)                        nxtState = SEED;
          else if (bitOk && (matchCnt == LOCK_LAST))  nxtState = LOCKED;
        end
        LOCKED:  if (!bitOk && (missCnt == LOSS_LAST)) nxtState = SEED;
        default: nxtState = SEED;
      endcase
    end
  end

  always_comb begin
    locked   = (curState == LOCKED);
    state    = curState;
    countErr = bitEn && (curState == LOCKED) && !bitOk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      seedCnt  <= '0;
      matchCnt <= '0;
      missCnt  <= '0;
      errPulse <= 1'b0;
      errCount <= '0;
    end else begin
      errPulse <= countErr;
      if (clrCount)                        errCount <= countErr ? ERR_W'(1) : '0;
      else if (countErr && errCount != '1) errCount <= errCount + 1'b1;

      if (bitEn) begin
        shadow <= shadowNxt;
        case (curState)
          SEED: begin
            seedCnt  <= seedCnt + 1'b1;
            matchCnt <= '0;
            missCnt  <= '0;
          end
          VERIFY: begin
            seedCnt  <= '0;
            matchCnt <= bitOk ? matchCnt + 1'b1 : '0;
            missCnt  <= '0;
          end
          LOCKED: begin
            seedCnt <= '0;
            missCnt <= bitOk ? '0 : missCnt + 1'b1;
          end
          default: seedCnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker driven by a reference PRBS16 generator stream.
module tb_prbs16_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bitEn = 1'b0;
  logic        bitIn = 1'b0;
  logic        clrCount = 1'b0;
  logic        locked;
  logic        errPulse;
  logic [15:0] errCount;
  logic [1:0]  state;

  logic [15:0] gen;
  int          vectors = 0;
  int          miscompares = 0;

  prbs16_checker #(.LOCK_COUNT(32), .LOSS_COUNT(8), .ERR_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bitEn    (bitEn),
    .bitIn    (bitIn),
    .clrCount (clrCount),
    .locked   (locked),
    .errPulse (errPulse),
    .errCount (errCount),
    .state    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic genNext(output logic b);
    b   = gen[15] ^ gen[12] ^ gen[11] ^ gen[10];
    gen = {gen[14:0], b};
  endtask

  task automatic step(input logic en, input logic b, input logic clr);
    bitEn    = en;
    bitIn    = b;
    clrCount = clr;
    @(posedge clk);
    #1;
    bitEn    = 1'b0;
    clrCount = 1'b0;
  endtask

  task automatic sendGen(input logic invert);
    logic b;
    genNext(b);
    step(1'b1, b ^ invert, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    vectors++; if (locked !== 1'b0)    begin miscompares++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    vectors++; if (errPulse !== 1'b0)  begin miscompares++; $display("FAIL reset_errPulse: got %0b expected 0", errPulse); end
    vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL reset_errCount: got %0d expected 0", errCount); end
    vectors++; if (state !== 2'd0)     begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
  endtask

  task automatic test_clean_lock();
    int pulses = 0;
    gen = 16'hFFFF;
    for (int i = 1; i <= 15; i++) sendGen(1'b0);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL lock_seed15: got %0d expected 0", state); end
    sendGen(1'b0);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL lock_verify16: got %0d expected 1", state); end
    for (int i = 17; i <= 47; i++) sendGen(1'b0);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_bit47: got %0b expected 0", locked); end
    sendGen(1'b0);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_bit48: got %0b expected 1", locked); end
    vectors++; if (state !== 2'd2)  begin miscompares++; $display("FAIL lock_state48: got %0d expected 2", state); end
    for (int i = 0; i < 1000; i++) begin
      sendGen(1'b0);
      if (errPulse) pulses++;
    end
    vectors++; if (pulses !== 0)       begin miscompares++; $display("FAIL clean_pulses: got %0d expected 0", pulses); end
    vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL clean_errCount: got %0d expected 0", errCount); end
    vectors++; if (locked !== 1'b1)    begin miscompares++; $display("FAIL clean_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    sendGen(1'b1);
    vectors++; if (errPulse !== 1'b1)  begin miscompares++; $display("FAIL single_pulse: got %0b expected 1", errPulse); end
    vectors++; if (errCount !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", errCount); end
    for (int i = 0; i < 50; i++) begin
      sendGen(1'b0);
      if (errPulse) pulses++;
    end
    vectors++; if (pulses !== 0)       begin miscompares++; $display("FAIL single_flywheel: got %0d pulses expected 0", pulses); end
    vectors++; if (errCount !== 16'd1) begin miscompares++; $display("FAIL single_count_after: got %0d expected 1", errCount); end
    vectors++; if (locked !== 1'b1)    begin miscompares++; $display("FAIL single_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_loss_of_lock();
    step(1'b0, 1'b0, 1'b1);
    vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL clr_alone: got %0d expected 0", errCount); end
    for (int i = 1; i <= 7; i++) sendGen(1'b1);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_bit7: got %0b expected 1", locked); end
    sendGen(1'b1);
    vectors++; if (locked !== 1'b0)    begin miscompares++; $display("FAIL loss_locked: got %0b expected 0", locked); end
    vectors++; if (state !== 2'd0)     begin miscompares++; $display("FAIL loss_state: got %0d expected 0", state); end
    vectors++; if (errCount !== 16'd8) begin miscompares++; $display("FAIL loss_count: got %0d expected 8", errCount); end
    for (int i = 1; i <= 47; i++) sendGen(1'b0);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL relock_bit47: got %0b expected 0", locked); end
    sendGen(1'b0);
    vectors++; if (locked !== 1'b1)    begin miscompares++; $display("FAIL relock_bit48: got %0b expected 1", locked); end
    vectors++; if (errCount !== 16'd8) begin miscompares++; $display("FAIL relock_count: got %0d expected 8", errCount); end
  endtask

  task automatic test_zero_rejection();
    int lockSeen = 0;
    doReset();
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL zero_verify: got %0d expected 1", state); end
    step(1'b1, 1'b0, 1'b0);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL zero_reseed: got %0d expected 0", state); end
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) lockSeen++;
    end
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL zero_verify2: got %0d expected 1", state); end
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) lockSeen++;
    end
    vectors++; if (lockSeen !== 0)     begin miscompares++; $display("FAIL zero_locked: got %0d expected 0", lockSeen); end
    vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL zero_count: got %0d expected 0", errCount); end
  endtask

  task automatic test_gaps_and_clear();
    logic b;
    doReset();
    gen = 16'hFFFF;
    for (int i = 1; i <= 48; i++) begin
      sendGen(1'b0);
      if (i == 47) begin
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL gap_bit47: got %0b expected 0", locked); end
      end
      step(1'b0, 1'($urandom_range(1)), 1'b0);
    end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL gap_bit48: got %0b expected 1", locked); end
    sendGen(1'b1);
    vectors++; if (errCount !== 16'd1) begin miscompares++; $display("FAIL gap_err: got %0d expected 1", errCount); end
    step(1'b0, 1'b1, 1'b0);
    vectors++; if (errPulse !== 1'b0) begin miscompares++; $display("FAIL gap_pulse_idle: got %0b expected 0", errPulse); end
    sendGen(1'b0);
    sendGen(1'b1);
    vectors++; if (errCount !== 16'd2) begin miscompares++; $display("FAIL gap_err2: got %0d expected 2", errCount); end
    sendGen(1'b0);
    genNext(b);
    step(1'b1, ~b, 1'b1);
    vectors++; if (errCount !== 16'd1) begin miscompares++; $display("FAIL clr_with_err: got %0d expected 1", errCount); end
    vectors++; if (errPulse !== 1'b1)  begin miscompares++; $display("FAIL clr_with_err_pulse: got %0b expected 1", errPulse); end
    vectors++; if (locked !== 1'b1)    begin miscompares++; $display("FAIL clr_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_reset_mid();
    logic b;
    for (int i = 0; i < 4; i++) begin
      sendGen(1'b0);
      sendGen(1'b1);
    end
    vectors++; if (errCount !== 16'd5) begin miscompares++; $display("FAIL mid_count5: got %0d expected 5", errCount); end
    genNext(b);
    rst = 1'b1;
    step(1'b1, ~b, 1'b0);
    rst = 1'b0;
    vectors++; if (locked !== 1'b0)    begin miscompares++; $display("FAIL mid_locked: got %0b expected 0", locked); end
    vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL mid_count: got %0d expected 0", errCount); end
    vectors++; if (state !== 2'd0)     begin miscompares++; $display("FAIL mid_state: got %0d expected 0", state); end
    vectors++; if (errPulse !== 1'b0)  begin miscompares++; $display("FAIL mid_pulse: got %0b expected 0", errPulse); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_zero_rejection();
    test_gaps_and_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
